cdb_arbiter: RTL and testbench

Round-robin arbiter and output register for the Common Data Bus in the Tomasulo core. Five result producers (add, logic, mul, load, store reservation stations) raise requests with a tag/value pair. The arbiter grants at most one per cycle and drives the registered broadcast that reservation stations, register status and current-instruction logic snoop. It replaces the combinational CDB select and guarantees no producer starves.

---
 rtl/cdb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: five-way round-robin arbiter with a registered CDB broadcast.
// Optional: define CDB_TAG_CHECK_EN to refuse requests carrying INVALID_TAG.
module cdb_arbiter #(
  parameter int TAG_W = 5,
  parameter int VAL_W = 32,
  parameter logic [TAG_W-1:0] INVALID_TAG = {TAG_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_request_add,
  input  logic             in_request_logic,
  input  logic             in_request_mul,
  input  logic             in_request_load,
  input  logic             in_request_store,
  input  logic [TAG_W-1:0] in_tag_add,
  input  logic [TAG_W-1:0] in_tag_logic,
  input  logic [TAG_W-1:0] in_tag_mul,
  input  logic [TAG_W-1:0] in_tag_load,
  input  logic [TAG_W-1:0] in_tag_store,
  input  logic [VAL_W-1:0] in_val_add,
  input  logic [VAL_W-1:0] in_val_logic,
  input  logic [VAL_W-1:0] in_val_mul,
  input  logic [VAL_W-1:0] in_val_load,
  input  logic [VAL_W-1:0] in_val_store,
  output logic             out_grant_add,
  output logic             out_grant_logic,
  output logic             out_grant_mul,
  output logic             out_grant_load,
  output logic             out_grant_store,
  output logic             out_broadcast,
  output logic [TAG_W-1:0] out_tag,
  output logic [VAL_W-1:0] out_val,
  output logic             out_tag_error
);

  localparam int N = 5;

  logic [N-1:0]     req;
  logic [TAG_W-1:0] tag [N];
  logic [VAL_W-1:0] val [N];

  logic [2:0]       ptr;
  logic [N-1:0]     last_grant;
  logic             bcast_q;
  logic [TAG_W-1:0] tag_q;
  logic [VAL_W-1:0] val_q;

  logic [N-1:0]     bad;
  logic [N-1:0]     elig;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [2:0]       off;
  logic [3:0]       sum;
  logic [2:0]       win_idx;
  logic             any;
  logic [N-1:0]     win;
  logic [TAG_W-1:0] tag_sel;
  logic [VAL_W-1:0] val_sel;

  assign req = {in_request_store, in_request_load,
                in_request_mul, in_request_logic,
                in_request_add};

  assign tag[0] = in_tag_add;
  assign tag[1] = in_tag_logic;
  assign tag[2] = in_tag_mul;
  assign tag[3] = in_tag_load;
  assign tag[4] = in_tag_store;

  assign val[0] = in_val_add;
  assign val[1] = in_val_logic;
  assign val[2] = in_val_mul;
  assign val[3] = in_val_load;
  assign val[4] = in_val_store;

`ifdef CDB_TAG_CHECK_EN
  always_comb begin
    bad = '0;
    for (int i = 0; i < N; i++)
      bad[i] = req[i] && (tag[i] == INVALID_TAG);
  end
`else
  assign bad = '0;
`endif

  // last_grant masks a producer whose request is still up on the edge
  // at which it first sees its own grant.
  assign elig = req & ~last_grant & ~bad;
  assign any  = |elig;

  // Rotate so bit 0 is the requester at ptr; lowest set bit wins.
  assign dbl = {elig, elig};
  assign rot = N'(dbl >> ptr);

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = 3'(i);
  end

  assign sum     = 4'(ptr) + 4'(off);
  assign win_idx = (sum >= 4'd5) ? 3'(sum - 4'd5)
                                 : sum[2:0];
  assign win     = any ? (N'(1) << win_idx) : '0;

  always_comb begin
    tag_sel = INVALID_TAG;
    val_sel = '0;
    unique case (1'b1)
      win[0]: begin
        tag_sel = tag[0];
        val_sel = val[0];
      end
      win[1]: begin
        tag_sel = tag[1];
        val_sel = val[1];
      end
      win[2]: begin
        tag_sel = tag[2];
        val_sel = val[2];
      end
      win[3]: begin
        tag_sel = tag[3];
        val_sel = val[3];
      end
      win[4]: begin
        tag_sel = tag[4];
        val_sel = val[4];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      last_grant <= '0;
      bcast_q    <= 1'b0;
      tag_q      <= INVALID_TAG;
      val_q      <= '0;
    end else begin
      last_grant <= win;
      bcast_q    <= any;
      tag_q      <= tag_sel;
      val_q      <= val_sel;
      if (any)
        ptr <= (win_idx == 3'd4) ? 3'd0
                                 : win_idx + 3'd1;
    end
  end

`ifdef CDB_TAG_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (|bad)
      err_q <= 1'b1;
  end

  assign out_tag_error = err_q;
`else
  assign out_tag_error = 1'b0;
`endif

  // Grant pulses and the mask are the same one-hot register.
  assign out_grant_add   = last_grant[0];
  assign out_grant_logic = last_grant[1];
  assign out_grant_mul   = last_grant[2];
  assign out_grant_load  = last_grant[3];
  assign out_grant_store = last_grant[4];

  assign out_broadcast = bcast_q;
  assign out_tag       = tag_q;
  assign out_val       = val_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter.
// Expected grants are queued at stimulus time and popped per cycle.
module tb_cdb_arbiter;

  typedef struct {
    logic [4:0]  gnt;
    logic [4:0]  tag;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req = '0;
  logic [4:0]  tg [5];
  logic [31:0] vl [5];

  logic        g_add, g_logic, g_mul, g_load, g_store;
  logic        out_broadcast, out_tag_error;
  logic [4:0]  out_tag;
  logic [31:0] out_val;
  logic [4:0]  gv;
  logic [4:0]  seen;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   ncyc     = 0;
  int   lraise   = 0;
  logic exp_err  = 1'b0;

  always #5 clk = ~clk;

  assign gv = {g_store, g_load, g_mul, g_logic, g_add};

  cdb_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .in_request_add   (req[0]),
    .in_request_logic (req[1]),
    .in_request_mul   (req[2]),
    .in_request_load  (req[3]),
    .in_request_store (req[4]),
    .in_tag_add       (tg[0]),
    .in_tag_logic     (tg[1]),
    .in_tag_mul       (tg[2]),
    .in_tag_load      (tg[3]),
    .in_tag_store     (tg[4]),
    .in_val_add       (vl[0]),
    .in_val_logic     (vl[1]),
    .in_val_mul       (vl[2]),
    .in_val_load      (vl[3]),
    .in_val_store     (vl[4]),
    .out_grant_add    (g_add),
    .out_grant_logic  (g_logic),
    .out_grant_mul    (g_mul),
    .out_grant_load   (g_load),
    .out_grant_store  (g_store),
    .out_broadcast    (out_broadcast),
    .out_tag          (out_tag),
    .out_val          (out_val),
    .out_tag_error    (out_tag_error)
  );

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push(input int i);
    exp_t e;
    e.gnt = 5'b00001 << i;
    e.tag = tg[i];
    e.val = vl[i];
    sb.push_back(e);
  endtask

  // One clock; sample 1 time unit after the edge, then let producers react.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    ncyc++;
    seen = gv;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("bcast", out_broadcast, 1);
      check("grant", gv, e.gnt);
      check("tag", out_tag, e.tag);
      check("val", out_val, e.val);
    end else begin
      check("idle_bcast", out_broadcast, 0);
      check("idle_grant", gv, 0);
      check("idle_tag", out_tag, 5'h1f);
      check("idle_val", out_val, 0);
    end
    check("tag_err", out_tag_error, exp_err);
    for (int i = 0; i < 5; i++)
      if (gv[i]) req[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_err = 1'b0;
    step();
    rst = 1'b0;
    req = '0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      tg[i] = 5'(i + 1);
      vl[i] = 32'h100 + 32'(i);
    end

    // reset with every request raised, then quiet
    req = '1;
    step();
    step();
    rst = 1'b0;
    req = '0;
    step();

    // single producer
    tg[2] = 5'h02;
    vl[2] = 32'h6;
    req[2] = 1'b1;
    push(2);
    step();
    step();

    // all five at once from ptr=0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tg[i] = 5'(i + 1);
      vl[i] = 32'hA000 + 32'(i);
      req[i] = 1'b1;
      push(i);
    end
    for (int i = 0; i < 6; i++) step();

    // add and load after a store grant: add first
    tg[0] = 5'h06; vl[0] = 32'hAD00;
    tg[3] = 5'h07; vl[3] = 32'h10AD;
    req[0] = 1'b1; req[3] = 1'b1;
    push(0); push(3);
    step(); step(); step();

    // ptr=4 now: store then mul, wrapping 4 -> 0
    tg[2] = 5'h08; vl[2] = 32'h0808;
    tg[4] = 5'h09; vl[4] = 32'h0909;
    req[2] = 1'b1; req[4] = 1'b1;
    push(4); push(2);
    step(); step(); step();

    // fairness: ptr=3; add/mul persistent, logic joins mid-stream
    tg[0] = 5'h0a; vl[0] = 32'h1111;
    tg[1] = 5'h0c; vl[1] = 32'h2222;
    tg[2] = 5'h0b; vl[2] = 32'h3333;
    req[0] = 1'b1; req[2] = 1'b1;
    push(0); push(2); push(0); push(1); push(2);
    push(0); push(2); push(0); push(2);
    for (int k = 0; k < 9; k++) begin
      step();
      if (seen[1]) check("logic_lat", ncyc - lraise, 1);
      if (k < 7) begin
        if (seen[0]) req[0] = 1'b1;
        if (seen[2]) req[2] = 1'b1;
      end
      if (k == 2) begin
        req[1] = 1'b1;
        lraise = ncyc;
      end
    end
    step();

    // request carrying the idle tag
    do_reset();
    tg[0] = 5'h03; vl[0] = 32'h0303;
    tg[1] = 5'h1f; vl[1] = 32'h1f1f;
    req[0] = 1'b1; req[1] = 1'b1;
`ifdef CDB_TAG_CHECK_EN
    push(0);
    exp_err = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("bad_req_held", req[1], 1);
    req[1] = 1'b0;
    step();
    do_reset();
    step();
`else
    push(0); push(1);
    for (int i = 0; i < 4; i++) step();
`endif

    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_checks);
    $finish;
  end

endmodule
